// File: rtl/data_mem_arb_pkg.sv
// Shared constants and types for the two-requester data memory arbiter.
// Used with or without the DATA_MEM_ARB_LOCK_EN build option.
package data_mem_arb_pkg;

  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_BE_W     = DEF_DATA_W / 8;
  localparam int DEF_DEPTH    = 342;
  localparam int DEF_MAX_LOCK = 16;

  typedef logic req_idx_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_READ,
    ACC_WRITE
  } acc_t;

  // A request carrying both read and write is treated as a write.
  function automatic acc_t acc_type(input logic rd, input logic wr);
    if (wr) return ACC_WRITE;
    if (rd) return ACC_READ;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last_grant register. With DATA_MEM_ARB_LOCK_EN
// defined, a locked owner may keep the grant for up to MAX_LOCK consecutive grants.
module rr_arb2
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
`ifdef DATA_MEM_ARB_LOCK_EN
  input  logic [1:0] i_lock,
`endif
  output logic [1:0] o_grant,
  output req_idx_t   o_winner
);

  req_idx_t r_last_grant;
  req_idx_t w_winner;
  logic     w_any;

  assign w_any = |i_req;

`ifdef DATA_MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [CNT_W-1:0] r_lock_cnt;
  logic             w_hold;

  assign w_hold = i_req[r_last_grant] & i_lock[r_last_grant]
                & (r_lock_cnt < CNT_W'(MAX_LOCK));

  // Count consecutive locked grants held by the current owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_cnt <= '0;
    end else if (w_any) begin
      if (!i_lock[w_winner])
        r_lock_cnt <= '0;
      else if (w_winner != r_last_grant)
        r_lock_cnt <= CNT_W'(1);
      else if (r_lock_cnt < CNT_W'(MAX_LOCK))
        r_lock_cnt <= r_lock_cnt + CNT_W'(1);
    end else if (!i_lock[r_last_grant]) begin
      r_lock_cnt <= '0;
    end
  end
`endif

  always_comb begin
    w_winner = i_req[1];
    if (&i_req)
      w_winner = ~r_last_grant;
`ifdef DATA_MEM_ARB_LOCK_EN
    if (w_hold)
      w_winner = r_last_grant;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_last_grant <= 1'b1;
    else if (w_any)
      r_last_grant <= w_winner;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign o_grant[gi] = i_req[gi] & (w_winner == 1'(gi));
  end

  assign o_winner = w_winner;

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between two Avalon-MM requesters with
// round-robin grant and out-of-range guarding. Optional lock: DATA_MEM_ARB_LOCK_EN.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BE_W     = DATA_W / 8,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [BE_W-1:0]   r0_byteenable,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [BE_W-1:0]   r1_byteenable,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,
`ifdef DATA_MEM_ARB_LOCK_EN
  input  logic              r0_lock,
  input  logic              r1_lock,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              oor_err
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  req_idx_t          w_sel;
  logic              w_any;
  logic              w_oor;
  acc_t              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;

  logic     r_rd_pend;
  req_idx_t r_rd_owner;
  logic     r_rd_oor;
  logic     r_oor_err;

  assign w_req = {r1_read | r1_write, r0_read | r0_write};
  assign w_any = |w_req;

  rr_arb2 #(
    .MAX_LOCK(MAX_LOCK)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (w_req),
`ifdef DATA_MEM_ARB_LOCK_EN
    .i_lock  ({r1_lock, r0_lock}),
`endif
    .o_grant (w_grant),
    .o_winner(w_sel)
  );

  always_comb begin
    w_addr  = r0_address;
    w_be    = r0_byteenable;
    w_wdata = r0_writedata;
    w_acc   = acc_type(r0_read, r0_write);
    if (w_sel) begin
      w_addr  = r1_address;
      w_be    = r1_byteenable;
      w_wdata = r1_writedata;
      w_acc   = acc_type(r1_read, r1_write);
    end
  end

  // Out-of-range accesses are still accepted; only the memory strobe is withheld.
  assign w_oor          = w_any & (w_addr >= ADDR_LIMIT);
  assign mem_chipselect = w_any & ~w_oor;
  assign mem_write      = mem_chipselect & (w_acc == ACC_WRITE);
  assign mem_address    = w_any ? w_addr  : '0;
  assign mem_byteenable = w_any ? w_be    : '0;
  assign mem_writedata  = w_any ? w_wdata : '0;
  assign mem_clken      = 1'b1;

  assign r0_waitrequest = w_req[0] & ~w_grant[0];
  assign r1_waitrequest = w_req[1] & ~w_grant[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_oor_err  <= 1'b0;
    end else begin
      r_rd_pend  <= w_any & (w_acc == ACC_READ);
      r_rd_owner <= w_sel;
      r_rd_oor   <= w_oor;
      r_oor_err  <= w_oor;
    end
  end

  // Read data passes straight from the memory in the return cycle; out-of-range reads return 0.
  assign r0_readdatavalid = r_rd_pend & ~r_rd_owner;
  assign r1_readdatavalid = r_rd_pend &  r_rd_owner;
  assign r0_readdata      = (r0_readdatavalid & ~r_rd_oor) ? mem_readdata : '0;
  assign r1_readdata      = (r1_readdatavalid & ~r_rd_oor) ? mem_readdata : '0;
  assign oor_err          = r_oor_err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural memory and a read-return
// scoreboard. The lock sequence is exercised when DATA_MEM_ARB_LOCK_EN is defined.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  r0_address, r1_address;
  logic [3:0]  r0_byteenable, r1_byteenable;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_writedata, r1_writedata;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
`ifdef DATA_MEM_ARB_LOCK_EN
  logic        r0_lock = 1'b0;
  logic        r1_lock = 1'b0;
`endif
  logic [8:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        oor_err;

  int n_checks = 0;
  int n_pass   = 0;
  int oor_cnt  = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] mem [0:511];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read),
    .r0_write(r0_write), .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read),
    .r1_write(r1_write), .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
`ifdef DATA_MEM_ARB_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .oor_err(oor_err)
  );

  // Single-port memory with one-cycle registered read.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
    mem[5]   <= 32'hDEADBEEF;
    mem[342] <= 32'h12345678;
    mem[400] <= 32'hCAFEF00D;
  end

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Scoreboard monitor: every read return must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (r0_readdatavalid) begin
        if (q0.size() == 0) begin
          chk1("r0_unexpected_rdv", r0_readdatavalid, 1'b0);
        end else begin
          mon_exp = q0.pop_front();
          $display("r0 read return 0x%08h (expect 0x%08h)", r0_readdata, mon_exp);
          chk("r0_readdata", r0_readdata, mon_exp);
          chk1("r1_rdv_quiet", r1_readdatavalid, 1'b0);
          chk("r1_rdata_zero", r1_readdata, 32'h0);
        end
      end
      if (r1_readdatavalid) begin
        if (q1.size() == 0) begin
          chk1("r1_unexpected_rdv", r1_readdatavalid, 1'b0);
        end else begin
          mon_exp = q1.pop_front();
          $display("r1 read return 0x%08h (expect 0x%08h)", r1_readdata, mon_exp);
          chk("r1_readdata", r1_readdata, mon_exp);
          chk1("r0_rdv_quiet", r0_readdatavalid, 1'b0);
          chk("r0_rdata_zero", r0_readdata, 32'h0);
        end
      end
      if (oor_err) oor_cnt++;
    end
  end

  task automatic drive0(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    r0_read = rd; r0_write = wr; r0_address = a; r0_byteenable = be; r0_writedata = d;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    r1_read = rd; r1_write = wr; r1_address = a; r1_byteenable = be; r1_writedata = d;
  endtask

  task automatic idle_all();
    drive0(1'b0, 1'b0, 9'd0, 4'h0, 32'h0);
    drive1(1'b0, 1'b0, 9'd0, 4'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    reset_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_r0_rdv", r0_readdatavalid, 1'b0);
    chk1("rst_r1_rdv", r1_readdatavalid, 1'b0);
    chk("rst_r0_rdata", r0_readdata, 32'h0);
    chk("rst_r1_rdata", r1_readdata, 32'h0);
    chk1("rst_oor_err", oor_err, 1'b0);
    reset_n = 1'b1;
    next_cycle();

    // Contention straight after reset: grants alternate r0, r1, r0, r1.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kb;
      kb = 2'(k);
      drive0(1'b0, 1'b1, 9'd10, 4'hF, 32'hA0A0A0A0);
      drive1(1'b0, 1'b1, 9'd11, 4'hF, 32'hB1B1B1B1);
      @(negedge clk);
      $display("contention cycle %0d: wait0=%b wait1=%b", k, r0_waitrequest, r1_waitrequest);
      chk1("cont_r0_wait", r0_waitrequest, kb[0]);
      chk1("cont_r1_wait", r1_waitrequest, ~kb[0]);
      chk1("cont_mem_write", mem_write, 1'b1);
      chk("cont_mem_addr", 32'(mem_address), kb[0] ? 32'd11 : 32'd10);
      next_cycle();
    end
    idle_all();

    // Single read of a preloaded word.
    drive0(1'b1, 1'b0, 9'd5, 4'hF, 32'h0);
    @(negedge clk);
    chk1("rd_r0_wait", r0_waitrequest, 1'b0);
    chk1("rd_mem_cs", mem_chipselect, 1'b1);
    q0.push_back(32'hDEADBEEF);
    next_cycle();
    idle_all();
    next_cycle();

    // Byte-lane write followed immediately by a read of the same word.
    drive1(1'b0, 1'b1, 9'd7, 4'b0101, 32'hAABBCCDD);
    @(negedge clk);
    chk1("bw_r1_wait", r1_waitrequest, 1'b0);
    next_cycle();
    drive1(1'b1, 1'b0, 9'd7, 4'hF, 32'h0);
    q1.push_back(32'h00BB00DD);
    @(negedge clk);
    chk1("br_r1_wait", r1_waitrequest, 1'b0);
    next_cycle();
    idle_all();

    // Back-to-back readback of the contention results.
    drive0(1'b1, 1'b0, 9'd10, 4'hF, 32'h0);
    q0.push_back(32'hA0A0A0A0);
    next_cycle();
    drive0(1'b1, 1'b0, 9'd11, 4'hF, 32'h0);
    q0.push_back(32'hB1B1B1B1);
    next_cycle();
    idle_all();
    next_cycle();

    // Out-of-range write then read.
    base = oor_cnt;
    drive0(1'b0, 1'b1, 9'd342, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    chk1("oor_w_wait", r0_waitrequest, 1'b0);
    chk1("oor_w_cs", mem_chipselect, 1'b0);
    next_cycle();
    drive0(1'b1, 1'b0, 9'd400, 4'hF, 32'h0);
    q0.push_back(32'h0);
    @(negedge clk);
    chk1("oor_r_cs", mem_chipselect, 1'b0);
    chk1("oor_err_w", oor_err, 1'b1);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk1("oor_err_r", oor_err, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("oor_err_clear", oor_err, 1'b0);
    chk("oor_pulses", 32'(oor_cnt - base), 32'd2);
    chk("oor_mem342", mem[342], 32'h12345678);
    chk("oor_mem400", mem[400], 32'hCAFEF00D);
    next_cycle();

    // Reset while a read is in flight: no return afterwards, r0 wins next contention.
    drive0(1'b1, 1'b0, 9'd5, 4'hF, 32'h0);
    @(negedge clk);
    chk1("rstrd_r0_wait", r0_waitrequest, 1'b0);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1 idle_all();
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk1("rstrd_no_rdv", r0_readdatavalid, 1'b0);
    next_cycle();
    drive0(1'b1, 1'b0, 9'd5, 4'hF, 32'h0);
    drive1(1'b1, 1'b0, 9'd5, 4'hF, 32'h0);
    @(negedge clk);
    chk1("post_rst_r0_wait", r0_waitrequest, 1'b0);
    chk1("post_rst_r1_wait", r1_waitrequest, 1'b1);
    q0.push_back(32'hDEADBEEF);
    next_cycle();
    drive0(1'b0, 1'b0, 9'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk1("post_rst_r1_go", r1_waitrequest, 1'b0);
    q1.push_back(32'hDEADBEEF);
    next_cycle();
    idle_all();
    next_cycle();

`ifdef DATA_MEM_ARB_LOCK_EN
    // Locked r0 keeps the grant 16 times, then r1 is forced through once.
    r0_lock = 1'b1;
    for (int k = 0; k < 18; k++) begin
      logic r1_turn;
      r1_turn = (k == 16);
      drive0(1'b1, 1'b0, 9'd5, 4'hF, 32'h0);
      drive1(1'b1, 1'b0, 9'd5, 4'hF, 32'h0);
      @(negedge clk);
      $display("lock cycle %0d: wait0=%b wait1=%b", k, r0_waitrequest, r1_waitrequest);
      chk1("lock_r0_wait", r0_waitrequest, r1_turn);
      chk1("lock_r1_wait", r1_waitrequest, ~r1_turn);
      if (r1_turn) q1.push_back(32'hDEADBEEF);
      else q0.push_back(32'hDEADBEEF);
      next_cycle();
    end
    r0_lock = 1'b0;
    idle_all();
`endif

    repeat (3) @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
